mic_sample_capture: RTL and testbench
=====================================

Name: mic_sample_capture

Overview:
Sample-frame responder for the start/done handshake issued by the audio top-level sequencer. On request it captures N_SAMPLES microphone ADC readings at a fixed sub-rate derived from the single system clock. It holds the frame stable and raises done until the requester drops start. Its output frame feeds the 4-point FFT inputs.

Parameters:
N_SAMPLES, 4, samples per frame (power of two, 2..16)
SAMPLE_W, 12, ADC sample width in bits
DIV, 12500, clk cycles per sample tick (12500 gives 4 kHz from 50 MHz); must be at least 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level request from the sequencer; four-phase handshake
mic  input  SAMPLE_W  live ADC channel-0 value, unsigned
samples  output  N_SAMPLES*SAMPLE_W  packed frame; sample i occupies bits [i*SAMPLE_W +: SAMPLE_W]; index 0 is the oldest
done  output  1  frame complete and stable
busy  output  1  capture in progress

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Input register: mic_q <= mic every cycle. Stored samples always come from mic_q, so each stored value is the mic value one edge earlier.
- Reset values: state=IDLE, samples=0, done=0, busy=0, tick counter=0, sample index=0, mic_q=0.
- States:
  - IDLE: done=0, busy=0. If start=1 at edge k, go to CAPTURE; clear the tick counter and the index.
  - CAPTURE: busy=1. The tick counter counts 0..DIV-1.
    - When the counter is at DIV-1, store mic_q into samples[index], increment index, reset the counter.
    - Sample i is written at edge k+(i+1)*DIV.
    - On the edge that writes index N_SAMPLES-1, go to DONE.
  - DONE: done=1, busy=0. samples are frozen. Stay while start=1; on the first edge with start=0, return to IDLE (done falls).
- Latency: from the start-accept edge k, done is high after edge k+N_SAMPLES*DIV.
- Abort: start=0 during CAPTURE returns to IDLE on that edge with no done pulse. Partially written entries keep their new values; unwritten entries keep the previous frame. busy falls.
- start held high through DONE produces no re-trigger. A new frame requires start to go low, then high again.
- start=1 in the same cycle IDLE is entered from DONE: accepted on the next edge (one idle cycle minimum between frames).
- reset has priority over every other event in every state. reset mid-CAPTURE clears samples to 0.
- samples changes only on capture edges (or reset). It never changes while done=1.
- The counter width is ceil(log2(DIV)) bits and the index width is ceil(log2(N_SAMPLES)) bits. The index wraps only via the DONE transition and never aliases.

Optional Feature:
MIC_DC_REMOVE_EN
- Defined: each stored value is mic_q - 2^(SAMPLE_W-1), i.e. mic_q with its MSB inverted, read as two's complement (0x800 becomes 0x000, 0x000 becomes 0x800 = -2048, 0xFFF becomes 0x7FF). This lets the downstream sign-extension into the FFT produce zero-centred data.
- Undefined: raw unsigned mic_q is stored.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic frame (DIV=4, N=4): reset, drive mic=0x100,0x200,0x300,0x400 in sequence, each value held for the 4 cycles preceding its tick edge (mic_q captured at edges k+4,8,12,16); raise start at edge k -> busy high edges k+1..k+16; done high after edge k+16; samples = {0x400,0x300,0x200,0x100}.
- Handshake hold: keep start=1 for 50 cycles after done -> done stays 1, samples unchanged, no new capture. Drop start -> done=0 next edge. Raise start again -> new frame completes 16 cycles after accept.
- Abort: drop start at edge k+9 -> IDLE, no done, busy=0. samples[0..1] hold the new values, samples[2..3] hold the old ones.
- Reset mid-capture: assert reset at edge k+6 -> next edge samples=0, done=0, busy=0. Deassert reset, raise start -> full frame captured normally.
- Back-to-back: start falls and rises in consecutive cycles after done -> exactly one idle cycle, then capture. Done latency is still N*DIV from the accept edge.
- MIC_DC_REMOVE_EN build: mic=0x800, 0x000, 0xFFF, 0x801 -> samples = {0x001, 0x7FF, 0x800, 0x000}. Non-EN build stores the raw values.

Source files
------------

// File: rtl/mic_sample_capture.sv
// -----------------------------------------------------------------------------
// mic_sample_capture
//
// Captures one frame of N_SAMPLES microphone ADC readings. The sequencer
// requests it with a four-phase start/done handshake. Samples are taken once
// every DIV clk cycles from a registered copy of the ADC input. The finished
// frame is held stable with done high until start is dropped.
//
// Optional build macro:
//   MIC_DC_REMOVE_EN - store each sample with its MSB inverted. The unsigned
//                      reading then becomes a zero-centred two's-complement
//                      value (mic - 2^(SAMPLE_W-1)). Timing is unchanged.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   level request, four-phase handshake
//   mic     in   [SAMPLE_W-1:0] live ADC reading, unsigned
//   samples out  [N_SAMPLES*SAMPLE_W-1:0] frame; sample i at [i*SAMPLE_W +: SAMPLE_W],
//                index 0 is the oldest
//   done    out  frame complete and stable
//   busy    out  capture in progress
// -----------------------------------------------------------------------------
module mic_sample_capture #(
    parameter int N_SAMPLES = 4,
    parameter int SAMPLE_W  = 12,
    parameter int DIV       = 12500
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [SAMPLE_W-1:0]             mic,
    output logic [N_SAMPLES*SAMPLE_W-1:0]   samples,
    output logic                            done,
    output logic                            busy
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [SAMPLE_W-1:0]    r_mic_q;
    logic [SAMPLE_W-1:0]    r_samples [N_SAMPLES];
    logic                   w_tick;
    logic [SAMPLE_W-1:0]    w_store_val;

    // A sample is stored only while the request is still held. An abort that
    // lands on a tick edge takes priority and stores nothing.
    assign w_tick = (r_state == S_CAPTURE) && start && (r_cnt == CNT_LAST);

`ifdef MIC_DC_REMOVE_EN
    // Inverting the MSB is the same as subtracting half scale, read as signed.
    assign w_store_val = {~r_mic_q[SAMPLE_W-1], r_mic_q[SAMPLE_W-2:0]};
`else
    assign w_store_val = r_mic_q;
`endif

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end else if (w_tick && (r_idx == IDX_LAST)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: input register, tick counter, sample index and frame storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mic_q <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_samples[i] <= '0;
            end
        end else begin
            r_mic_q <= mic;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                S_CAPTURE: begin
                    if (w_tick) begin
                        r_samples[r_idx] <= w_store_val;
                        r_cnt            <= '0;
                        // Wraps to zero on the final sample since N_SAMPLES is
                        // a power of two; IDLE clears it again anyway.
                        r_idx            <= r_idx + 1'b1;
                    end else if (start) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: frame frozen
                end
            endcase
        end
    end

    assign done = (r_state == S_DONE);
    assign busy = (r_state == S_CAPTURE);

    genvar gi;
    generate
        for (gi = 0; gi < N_SAMPLES; gi++) begin : g_pack
            assign samples[gi*SAMPLE_W +: SAMPLE_W] = r_samples[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mic_sample_capture.sv
module tb_mic_sample_capture;

    localparam int N  = 4;
    localparam int SW = 12;
    localparam int DV = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [SW-1:0]     mic;
    logic [N*SW-1:0]   samples;
    logic              done;
    logic              busy;

    int passed = 0;
    int total  = 0;

    mic_sample_capture #(
        .N_SAMPLES (N),
        .SAMPLE_W  (SW),
        .DIV       (DV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mic     (mic),
        .samples (samples),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Accept a frame (edge k) then run 16 edges, holding each mic value for
    // the 4 edges ending at its tick edge. Checks busy/done every cycle and the
    // done latency of exactly N*DIV edges from accept.
    task automatic capture_frame(input string tag, input logic [N*SW-1:0] vals,
                                 input logic [N*SW-1:0] exp_frame);
        start = 1'b1;
        tick();                              // edge k
        chk({tag, "_busy_k"}, {63'd0, busy}, 64'd1);
        for (int s = 0; s < N; s++) begin
            mic = vals[s*SW +: SW];
            for (int c = 0; c < DV; c++) begin
                tick();
                if (!(s == N-1 && c == DV-1)) begin
                    chk({tag, "_busy_run"}, {62'd0, busy, done}, 64'd2);
                end
            end
        end
        chk({tag, "_done_k16"}, {62'd0, busy, done}, 64'd1);
        chk({tag, "_frame"}, {16'd0, samples}, {16'd0, exp_frame});
        $display("frame %s: samples=%h done=%0b busy=%0b", tag, samples, done, busy);
    endtask

    logic [N*SW-1:0] frame_a;
    logic [N*SW-1:0] frame_b;
    logic [N*SW-1:0] dc_in;
    logic [N*SW-1:0] dc_exp;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mic   = '0;
        tick();
        tick();
        chk("reset_samples", {16'd0, samples}, 64'd0);
        chk("reset_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_flags", {62'd0, busy, done}, 64'd0);

        // Basic frame
        frame_a = {12'h400, 12'h300, 12'h200, 12'h100};
        capture_frame("basic", frame_a, frame_a);

        // Handshake hold: start stays high, mic keeps moving
        for (int i = 0; i < 50; i++) begin
            mic = SW'(i * 37 + 5);
            tick();
            if (i % 10 == 9) begin
                chk("hold_done", {62'd0, busy, done}, 64'd1);
                chk("hold_frame", {16'd0, samples}, {16'd0, frame_a});
            end
        end
        start = 1'b0;
        tick();
        chk("drop_done", {62'd0, busy, done}, 64'd0);
        $display("handshake drop: done=%0b busy=%0b", done, busy);
        tick();

        // Second frame after re-raise
        frame_b = {12'hABC, 12'h123, 12'hFFF, 12'h001};
        capture_frame("second", frame_b, frame_b);

        // Back-to-back: drop for one edge, raise on the next
        start = 1'b0;
        tick();
        chk("b2b_idle", {62'd0, busy, done}, 64'd0);
        capture_frame("b2b", frame_a, frame_a);

        // Abort at k+9: samples 0,1 written, 2,3 keep the previous frame
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();                              // edge k
        mic = 12'h0AA;
        repeat (4) tick();                   // k+4 stores 0x0AA
        mic = 12'h0BB;
        repeat (4) tick();                   // k+8 stores 0x0BB
        start = 1'b0;
        tick();                              // k+9
        chk("abort_flags", {62'd0, busy, done}, 64'd0);
        chk("abort_frame", {16'd0, samples}, {16'd0, 12'h400, 12'h300, 12'h0BB, 12'h0AA});
        repeat (20) tick();
        chk("abort_no_done", {62'd0, busy, done}, 64'd0);
        chk("abort_frozen", {16'd0, samples}, {16'd0, 12'h400, 12'h300, 12'h0BB, 12'h0AA});
        $display("abort: samples=%h", samples);

        // Reset mid-capture at k+6
        start = 1'b1;
        mic   = 12'h555;
        tick();                              // edge k
        repeat (5) tick();                   // k+5, sample 0 already written
        chk("pre_reset_s0", {52'd0, samples[SW-1:0]}, 64'h555);
        reset = 1'b1;
        start = 1'b0;
        tick();                              // k+6
        chk("midreset_samples", {16'd0, samples}, 64'd0);
        chk("midreset_flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;
        tick();
        capture_frame("post_reset", frame_b, frame_b);

        // Stored-value transform (raw or DC-removed depending on the build)
        start = 1'b0;
        tick();
        dc_in = {12'h801, 12'hFFF, 12'h000, 12'h800};
`ifdef MIC_DC_REMOVE_EN
        dc_exp = {12'h001, 12'h7FF, 12'h800, 12'h000};
`else
        dc_exp = {12'h801, 12'hFFF, 12'h000, 12'h800};
`endif
        capture_frame("dc", dc_in, dc_exp);
        start = 1'b0;
        tick();
        chk("final_idle", {62'd0, busy, done}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
